// File: rtl/snake_move_sched_pkg.sv
// snake_move_sched_pkg: direction codes, FSM states and direction helpers shared by the snake blocks.
// Contents:
//   dir_t       3-bit direction codes as driven by move_input
//   state_t     scheduler FSM states
//   opposite()  direction that would be a 180-degree reversal
//   dir_legal() 1 when a raw code may load the pending direction
package snake_move_sched_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_OVER = 2'd3
    } state_t;

    function automatic logic [2:0] opposite(input dir_t d);
        return d == DIR_LEFT  ? DIR_RIGHT :
               d == DIR_RIGHT ? DIR_LEFT  :
               d == DIR_UP    ? DIR_DOWN  :
               d == DIR_DOWN  ? DIR_UP    : DIR_NONE;
    endfunction

    // Codes 0 and 5-7 never load; a reversal of the committed direction is dropped.
    function automatic logic dir_legal(input logic [2:0] code, input dir_t cur);
        return code >= 3'd1 && code <= 3'd4 && code != opposite(cur);
    endfunction

endpackage

// File: rtl/snake_move_sched_if.sv
// snake_move_sched_if: control and status bundle between the game logic and the head scheduler.
// Signals:
//   start, dir_in[2:0], eat          game logic -> scheduler
//   head_x[XW], head_y[YW], cur_dir,
//   length[8], step, running,
//   game_over                        scheduler -> game logic
// Modports: master (game logic side), slave (scheduler side).
interface snake_move_sched_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic          start;
    logic [2:0]    dir_in;
    logic          eat;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [2:0]    cur_dir;
    logic [7:0]    length;
    logic          step;
    logic          running;
    logic          game_over;

    modport master (
        output start, dir_in, eat,
        input  head_x, head_y, cur_dir, length, step, running, game_over
    );

    modport slave (
        input  start, dir_in, eat,
        output head_x, head_y, cur_dir, length, step, running, game_over
    );
endinterface

// File: rtl/snake_move_sched_tick_div.sv
// snake_move_sched_tick_div: enable-gated modulo-TICK_DIV counter with a terminal-count flag.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high; clears the count
//   en     in  count enable (scheduler RUN state)
//   tc     out high while the count sits at TICK_DIV-1
module snake_move_sched_tick_div #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tc = cnt == CW'(TICK_DIV - 1);

    // Wrapping on the RUN->STEP edge leaves the count at 0 through STEP and OVER,
    // so a restart from OVER always begins a full tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/snake_move_sched.sv
// snake_move_sched: snake head scheduler; filters reversals, commits one move per tick, detects walls, tracks length.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high; returns everything to IDLE values
//   bus    slave side of snake_move_sched_if:
//          start/dir_in/eat in; head_x/head_y/cur_dir/length/step/running/game_over out (all registered)
module snake_move_sched
    import snake_move_sched_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int XW       = 5,
    parameter int YW       = 5,
    parameter int START_X  = 4,
    parameter int START_Y  = 4,
    parameter int LEN_INIT = 3,
    parameter int LEN_MAX  = 255
) (
    input logic               clk,
    input logic               reset,
    snake_move_sched_if.slave bus
);
    state_t        state;
    dir_t          cur_dir, pend_dir;
    logic [XW-1:0] hx, nx;
    logic [YW-1:0] hy, ny;
    logic [7:0]    len;
    logic          step, running, game_over;
    logic          tc, wall, active;

    snake_move_sched_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == S_RUN),
        .tc    (tc)
    );

    assign active = state == S_RUN || state == S_STEP;

    always_comb begin
        nx   = pend_dir == DIR_LEFT ? hx - 1'b1 : pend_dir == DIR_RIGHT ? hx + 1'b1 : hx;
        ny   = pend_dir == DIR_UP   ? hy - 1'b1 : pend_dir == DIR_DOWN  ? hy + 1'b1 : hy;
        wall = (pend_dir == DIR_LEFT  && hx == '0) ||
               (pend_dir == DIR_RIGHT && hx == XW'(GRID_W - 1)) ||
               (pend_dir == DIR_UP    && hy == '0) ||
               (pend_dir == DIR_DOWN  && hy == YW'(GRID_H - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hx        <= XW'(START_X);
            hy        <= YW'(START_Y);
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            len       <= 8'(LEN_INIT);
            step      <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                S_IDLE, S_OVER: if (bus.start) begin
                    state     <= S_RUN;
                    hx        <= XW'(START_X);
                    hy        <= YW'(START_Y);
                    cur_dir   <= DIR_RIGHT;
                    pend_dir  <= DIR_RIGHT;
                    len       <= 8'(LEN_INIT);
                    running   <= 1'b1;
                    game_over <= 1'b0;
                end
                S_RUN: if (tc) state <= S_STEP;
                S_STEP: if (wall) begin
                    state     <= S_OVER;
                    running   <= 1'b0;
                    game_over <= 1'b1;
                end else begin
                    state   <= S_RUN;
                    hx      <= nx;
                    hy      <= ny;
                    cur_dir <= pend_dir;
                    step    <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
            // Reversal is judged against the committed direction, so a perpendicular
            // turn followed by the opposite of the current heading cannot slip through.
            if (active && dir_legal(bus.dir_in, cur_dir))
                pend_dir <= dir_t'(bus.dir_in);
            if (active && bus.eat && len != 8'(LEN_MAX))
                len <= len + 8'd1;
        end
    end

    assign bus.head_x    = hx;
    assign bus.head_y    = hy;
    assign bus.cur_dir   = cur_dir;
    assign bus.length    = len;
    assign bus.step      = step;
    assign bus.running   = running;
    assign bus.game_over = game_over;
endmodule
